// File: rtl/fifo_multichwrctrl_pkg.sv
// rtl/fifo_multichwrctrl_pkg.sv - controller state type and default field widths.
package fifo_multichwrctrl_pkg;

  localparam int DEF_WR_CHANNEL_CNT   = 5;
  localparam int DEF_WR_CHANNEL_DEPTH = 64;
  localparam int CH_SEL_W             = $clog2(DEF_WR_CHANNEL_CNT);
  localparam int CNT_W                = $clog2(DEF_WR_CHANNEL_DEPTH) + 1;

  typedef enum logic [1:0] {IDLE, SETTLE, STREAM, DONE} state_t;

endpackage

// File: rtl/fifo_multichwrctrl.sv
// rtl/fifo_multichwrctrl.sv - moves a commanded word count from an FWFT source into one channel of a FIFO bank.
// Optional stall watchdog enabled by FIFO_MULTICHWRCTRL_TIMEOUT_EN.
module fifo_multichwrctrl
  import fifo_multichwrctrl_pkg::*;
#(
  parameter int CHANNEL_WIDTH    = 32,
  parameter int WR_CHANNEL_CNT   = DEF_WR_CHANNEL_CNT,
  parameter int WR_CHANNEL_DEPTH = DEF_WR_CHANNEL_DEPTH,
  parameter int WR_DELAY_CYCLES  = 5,
  parameter int TIMEOUT_CYCLES   = 1024
) (
  input  logic                                  clk,
  input  logic                                  rst,
  input  logic                                  i_cmd_valid,
  input  logic [$clog2(WR_CHANNEL_CNT)-1:0]     i_cmd_wrchsel,
  input  logic [$clog2(WR_CHANNEL_DEPTH):0]     i_cmd_wrcnt,
  output logic                                  o_cmd_ready,
  output logic                                  o_cmd_done,
  output logic                                  o_cmd_error,
  output logic                                  o_timeout,
  input  logic                                  i_singlechannel_rd_valid,
  input  logic [CHANNEL_WIDTH-1:0]              i_singlechannel_rd_data,
  output logic                                  o_singlechannel_rd_en,
  output logic [WR_CHANNEL_CNT-1:0]             o_wr_en_channels,
  output logic [CHANNEL_WIDTH-1:0]              o_wr_data,
  input  logic [WR_CHANNEL_CNT-1:0]             i_ready_channels,
  input  logic [WR_CHANNEL_CNT-1:0]             i_full_next_channels
);

  localparam int SEL_W    = $clog2(WR_CHANNEL_CNT);
  localparam int CW       = $clog2(WR_CHANNEL_DEPTH) + 1;
  localparam int SETTLE_W = (WR_DELAY_CYCLES > 1) ? $clog2(WR_DELAY_CYCLES) : 1;

  state_t               state;
  logic [SEL_W-1:0]     sel;
  logic [CW-1:0]        remaining;
  logic [SETTLE_W-1:0]  settle_cnt;
  logic [CW-1:0]        cnt_clamped;
  logic                 bad_sel;
  logic                 xfer;
  logic                 timeout_hit;

  assign cnt_clamped = (i_cmd_wrcnt > CW'(WR_CHANNEL_DEPTH)) ? CW'(WR_CHANNEL_DEPTH) : i_cmd_wrcnt;
  assign bad_sel     = {1'b0, i_cmd_wrchsel} >= (SEL_W + 1)'(WR_CHANNEL_CNT);

  // A write still in flight to a one-slot-left channel would fill it, so hold off one cycle.
  assign xfer = (state == STREAM) && i_singlechannel_rd_valid && i_ready_channels[sel]
                && !(o_wr_en_channels[sel] && i_full_next_channels[sel]);
  assign o_singlechannel_rd_en = xfer;

`ifdef FIFO_MULTICHWRCTRL_TIMEOUT_EN
  localparam int TO_W = $clog2(TIMEOUT_CYCLES + 1);
  logic [TO_W-1:0] stall_cnt;

  always_ff @(posedge clk or posedge rst) begin
    if (rst)                           stall_cnt <= '0;
    else if (state != STREAM || xfer)  stall_cnt <= '0;
    else                               stall_cnt <= stall_cnt + 1'b1;
  end

  assign timeout_hit = !xfer && (stall_cnt == TO_W'(TIMEOUT_CYCLES - 1));
`else
  // watchdog compiled out; this comparison is always false
  assign timeout_hit = (TIMEOUT_CYCLES < 0);
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state            <= IDLE;
      sel              <= '0;
      remaining        <= '0;
      settle_cnt       <= '0;
      o_cmd_ready      <= 1'b1;
      o_cmd_done       <= 1'b0;
      o_cmd_error      <= 1'b0;
      o_timeout        <= 1'b0;
      o_wr_en_channels <= '0;
      o_wr_data        <= '0;
    end else begin
      o_cmd_done       <= 1'b0;
      o_cmd_error      <= 1'b0;
      o_timeout        <= 1'b0;
      o_wr_en_channels <= xfer ? (WR_CHANNEL_CNT'(1) << sel) : '0;
      if (xfer) o_wr_data <= i_singlechannel_rd_data;

      case (state)
        IDLE: begin
          if (i_cmd_valid) begin
            sel        <= i_cmd_wrchsel;
            remaining  <= cnt_clamped;
            settle_cnt <= '0;
            if (bad_sel) begin
              o_cmd_error <= 1'b1;
            end else if (cnt_clamped == '0) begin
              state       <= DONE;
              o_cmd_done  <= 1'b1;
              o_cmd_ready <= 1'b0;
            end else if (WR_DELAY_CYCLES == 0) begin
              state       <= STREAM;
              o_cmd_ready <= 1'b0;
            end else begin
              state       <= SETTLE;
              o_cmd_ready <= 1'b0;
            end
          end
        end
        SETTLE: begin
          if (settle_cnt == SETTLE_W'(WR_DELAY_CYCLES - 1)) state <= STREAM;
          else settle_cnt <= settle_cnt + 1'b1;
        end
        STREAM: begin
          if (xfer) begin
            remaining <= remaining - 1'b1;
            if (remaining == CW'(1)) begin
              state      <= DONE;
              o_cmd_done <= 1'b1;
            end
          end else if (timeout_hit) begin
            state      <= DONE;
            o_cmd_done <= 1'b1;
            o_timeout  <= 1'b1;
          end
        end
        DONE: begin
          state       <= IDLE;
          o_cmd_ready <= 1'b1;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
